// File: rtl/psr_cond_unit.sv
// CR16 PSR flag register with masked ALU update, LPR/SPR access and condition evaluation.
// Optional macro PSR_COND_BYPASS_EN: same-cycle flag writes feed the condition evaluator.
module psr_cond_unit #(
    parameter int P_WIDTH = 16
) (
    input  logic               I_CLK,
    input  logic               I_RESET,
    input  logic [4:0]         I_STATUS,
    input  logic               I_STATUS_WE,
    input  logic [4:0]         I_STATUS_MASK,
    input  logic               I_PSR_WR_EN,
    input  logic [P_WIDTH-1:0] I_PSR_WR_DATA,
    output logic [P_WIDTH-1:0] O_PSR,
    input  logic               I_COND_VALID,
    input  logic [3:0]         I_COND,
    output logic               O_COND_VALID,
    output logic               O_COND_TAKEN
);

    localparam int FC = 0;
    localparam int FL = 1;
    localparam int FF = 2;
    localparam int FZ = 3;
    localparam int FN = 4;

    logic [4:0] flags_q;
    logic [4:0] flags_d;
    logic [4:0] flags_eval;
    logic       valid_q;
    logic       valid_d;
    logic       taken_q;
    logic       taken_d;
    logic       cond_true;

    // LPR overrides any ALU status update in the same cycle
    always_comb begin
        flags_d = flags_q;
        if (I_PSR_WR_EN) begin
            flags_d = I_PSR_WR_DATA[4:0];
        end else if (I_STATUS_WE) begin
            flags_d = (I_STATUS & I_STATUS_MASK) | (flags_q & ~I_STATUS_MASK);
        end
    end

`ifdef PSR_COND_BYPASS_EN
    assign flags_eval = flags_d;
`else
    assign flags_eval = flags_q;
`endif

    always_comb begin
        cond_true = 1'b0;
        unique case (I_COND)
            4'h0: cond_true = flags_eval[FZ];
            4'h1: cond_true = ~flags_eval[FZ];
            4'h2: cond_true = flags_eval[FC];
            4'h3: cond_true = ~flags_eval[FC];
            4'h4: cond_true = flags_eval[FL];
            4'h5: cond_true = ~flags_eval[FL];
            4'h6: cond_true = flags_eval[FN];
            4'h7: cond_true = ~flags_eval[FN];
            4'h8: cond_true = flags_eval[FF];
            4'h9: cond_true = ~flags_eval[FF];
            4'hA: cond_true = ~flags_eval[FL] & ~flags_eval[FZ];
            4'hB: cond_true = flags_eval[FL] | flags_eval[FZ];
            4'hC: cond_true = ~flags_eval[FN] & ~flags_eval[FZ];
            4'hD: cond_true = flags_eval[FN] | flags_eval[FZ];
            4'hE: cond_true = 1'b1;
            4'hF: cond_true = 1'b0;
            default: cond_true = 1'b0;
        endcase
    end

    always_comb begin
        valid_d = I_COND_VALID;
        taken_d = I_COND_VALID & cond_true;
    end

    always_ff @(posedge I_CLK) begin
        if (I_RESET) begin
            flags_q <= 5'b0;
            valid_q <= 1'b0;
            taken_q <= 1'b0;
        end else begin
            flags_q <= flags_d;
            valid_q <= valid_d;
            taken_q <= taken_d;
        end
    end

    assign O_PSR        = {{(P_WIDTH-5){1'b0}}, flags_q};
    assign O_COND_VALID = valid_q;
    assign O_COND_TAKEN = taken_q;

endmodule
